// File: rtl/writeback_stage.sv
// Writeback stage: completes loads, selects the architectural result, writes the
// 32x32 register file, drives write-first decode read ports and the load forwarding pair.
module writeback_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR,
    input  logic [31:0] RD,
    input  logic [31:0] A,
    input  logic [31:0] PC,
    input  logic        v_in,
    input  logic        stall,
    output logic        r_out,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [4:0]  AW_out,
    output logic [31:0] WB_out,
    output logic [63:0] instret,
    output logic        err
);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    logic [31:0] rf_q [32];
    logic        r_out_q, r_out_d;
    logic [4:0]  aw_q, aw_d;
    logic [31:0] wb_q, wb_d;
    logic [63:0] instret_q, instret_d;
    logic        err_q, err_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_idx;
    logic        writes, load_bad, accept, wr_en;
    logic [31:0] result;
    logic        unused_ir;

    assign unused_ir = &{1'b0, IR[31:15]};

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = $signed(raw[7:0]);
        h = $signed(raw[15:0]);
        case (f3)
            3'b000:  load_ext = 32'(b);
            3'b001:  load_ext = 32'(h);
            3'b010:  load_ext = raw;
            3'b100:  load_ext = {24'd0, raw[7:0]};
            3'b101:  load_ext = {16'd0, raw[15:0]};
            default: load_ext = 32'd0;
        endcase
    endfunction

    // Reads see the value being written this cycle so decode never waits on the array.
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0)
            read_port = 32'd0;
        else if (wr_en && (addr == rd_idx))
            read_port = result;
        else
            read_port = rf_q[addr];
    endfunction

    always_comb begin
        opcode   = IR[6:0];
        funct3   = IR[14:12];
        rd_idx   = IR[11:7];
        writes   = 1'b0;
        load_bad = 1'b0;
        result   = 32'd0;
        case (opcode)
            OPC_LOAD: begin
                result = load_ext(funct3, RD);
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    load_bad = 1'b1;
                else
                    writes = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                result = PC + 32'd4;
                writes = 1'b1;
            end
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                result = A;
                writes = 1'b1;
            end
            default: ;
        endcase
        accept = v_in & r_out_q;
        wr_en  = accept & writes & (rd_idx != 5'd0);
    end

    always_comb begin
        r_out_d   = ~stall;
        aw_d      = wr_en ? rd_idx : 5'd0;
        wb_d      = accept ? result : wb_q;
        instret_d = accept ? instret_q + 64'd1 : instret_q;
        err_d     = err_q | (accept & load_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q   <= 1'b1;
            aw_q      <= 5'd0;
            wb_q      <= 32'd0;
            instret_q <= 64'd0;
            err_q     <= 1'b0;
        end else begin
            r_out_q   <= r_out_d;
            aw_q      <= aw_d;
            wb_q      <= wb_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'd0;
        end else if (wr_en) begin
            rf_q[rd_idx] <= result;
        end
    end

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    assign r_out   = r_out_q;
    assign AW_out  = aw_q;
    assign WB_out  = wb_q;
    assign instret = instret_q;
    assign err     = err_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboarded bench for writeback_stage: directed load/jump/x0/bypass/stall/error/reset
// cases plus a random OP burst checked against a bench-side register model.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IR, RD, A, PC;
    logic        v_in, stall;
    logic        r_out;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  AW_out;
    logic [31:0] WB_out;
    logic [63:0] instret;
    logic        err;

    typedef struct {
        logic [4:0]  aw;
        logic [31:0] wb;
        bit          chk_wb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    logic [63:0] exp_instret;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OP = 7'h33,
                           JAL = 7'h6F, JALR = 7'h67;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .IR(IR), .RD(RD), .A(A), .PC(PC),
        .v_in(v_in), .stall(stall), .r_out(r_out),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .AW_out(AW_out), .WB_out(WB_out), .instret(instret), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        mk = {17'd0, f3, rd, opc};
    endfunction

    task automatic issue(input string tag, input logic [31:0] ir, input logic [31:0] rdv,
                         input logic [31:0] a, input logic [31:0] pc,
                         input logic [4:0] exp_aw, input logic [31:0] exp_wb, input bit chk_wb);
        exp_t e;
        @(negedge clk);
        IR = ir; RD = rdv; A = a; PC = pc; v_in = 1'b1;
        sb.push_back('{aw: exp_aw, wb: exp_wb, chk_wb: chk_wb});
        if (exp_aw != 5'd0) model[exp_aw] = exp_wb;
        exp_instret++;
        @(posedge clk);
        #1;
        v_in = 1'b0;
        e = sb.pop_front();
        check({tag, ".aw"}, 64'(AW_out), 64'(e.aw));
        if (e.chk_wb) check({tag, ".wb"}, 64'(WB_out), 64'(e.wb));
        check({tag, ".instret"}, instret, exp_instret);
    endtask

    task automatic read_chk(input string tag, input logic [4:0] idx);
        rs2_addr = idx;
        #1;
        check(tag, 64'(rs2_data), 64'(model[idx]));
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; v_in = 1'b0;
        IR = 32'd0; RD = 32'd0; A = 32'd0; PC = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        exp_instret = 64'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #3 rst_n = 1'b0;
        #1;
        check("rst.r_out", 64'(r_out), 64'd1);
        check("rst.aw", 64'(AW_out), 64'd0);
        check("rst.wb", 64'(WB_out), 64'd0);
        check("rst.instret", instret, 64'd0);
        check("rst.err", 64'(err), 64'd0);
        read_chk("rst.x5", 5'd5);
        @(negedge clk);
        rst_n = 1'b1;

        issue("lb", mk(3'b000, 5'd5, LOAD), 32'h000000F0, 32'h0, 32'h0, 5'd5, 32'hFFFFFFF0, 1);
        @(posedge clk); #1;
        check("lb.aw_one_cycle", 64'(AW_out), 64'd0);
        read_chk("lb.x5", 5'd5);
        issue("lbu", mk(3'b100, 5'd5, LOAD), 32'h000000F0, 32'h0, 32'h0, 5'd5, 32'h000000F0, 1);
        read_chk("lbu.x5", 5'd5);
        issue("lhu", mk(3'b101, 5'd5, LOAD), 32'h1234ABCD, 32'h0, 32'h0, 5'd5, 32'h0000ABCD, 1);
        read_chk("lhu.x5", 5'd5);
        issue("lh", mk(3'b001, 5'd6, LOAD), 32'hFFFF8001, 32'h0, 32'h0, 5'd6, 32'hFFFF8001, 1);
        issue("lh_pos", mk(3'b001, 5'd6, LOAD), 32'hABCD7001, 32'h0, 32'h0, 5'd6, 32'h00007001, 1);
        issue("lw", mk(3'b010, 5'd8, LOAD), 32'h89ABCDEF, 32'h0, 32'h0, 5'd8, 32'h89ABCDEF, 1);
        read_chk("lw.x8", 5'd8);
        issue("jal", mk(3'b000, 5'd1, JAL), 32'h0, 32'h0, 32'h00000100, 5'd1, 32'h00000104, 1);
        read_chk("jal.x1", 5'd1);
        issue("jalr_wrap", mk(3'b000, 5'd2, JALR), 32'h0, 32'h0, 32'hFFFFFFFC, 5'd2, 32'h00000000, 1);
        read_chk("jalr.x2", 5'd2);
        issue("x0", mk(3'b000, 5'd0, OP), 32'h0, 32'hDEADBEEF, 32'h0, 5'd0, 32'hDEADBEEF, 1);
        read_chk("x0.read", 5'd0);
        issue("store", mk(3'b010, 5'd5, STORE), 32'h0, 32'h11111111, 32'h0, 5'd0, 32'h0, 0);
        read_chk("store.x5", 5'd5);

        // Bypass: the new value must appear before the edge that commits it.
        @(negedge clk);
        rs1_addr = 5'd7;
        IR = mk(3'b000, 5'd7, OP); A = 32'h55; v_in = 1'b1;
        #1;
        check("bypass.same_cycle", 64'(rs1_data), 64'h55);
        model[7] = 32'h55;
        exp_instret++;
        @(posedge clk); #1;
        v_in = 1'b0;
        check("bypass.after", 64'(rs1_data), 64'h55);
        check("bypass.aw", 64'(AW_out), 64'd7);

        // Stall for three edges; the transfer presented with the first stall edge still lands.
        @(negedge clk);
        stall = 1'b1; v_in = 1'b1; IR = mk(3'b000, 5'd9, OP); A = 32'h99;
        model[9] = 32'h99;
        exp_instret++;
        @(posedge clk); #1;
        check("stall.r_out0", 64'(r_out), 64'd0);
        check("stall.aw_first", 64'(AW_out), 64'd9);
        check("stall.instret_first", instret, exp_instret);
        IR = mk(3'b000, 5'd10, OP); A = 32'h77;
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall.r_out_low", 64'(r_out), 64'd0);
            check("stall.aw_idle", 64'(AW_out), 64'd0);
            check("stall.instret_frozen", instret, exp_instret);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #1;
        check("unstall.r_out1", 64'(r_out), 64'd1);
        check("unstall.instret_frozen", instret, exp_instret);
        model[10] = 32'h77;
        exp_instret++;
        @(posedge clk); #1;
        v_in = 1'b0;
        check("unstall.aw", 64'(AW_out), 64'd10);
        check("unstall.instret", instret, exp_instret);
        read_chk("stall.x9", 5'd9);
        read_chk("stall.x10", 5'd10);

        check("err.before", 64'(err), 64'd0);
        issue("bad_load", mk(3'b011, 5'd4, LOAD), 32'hCAFEF00D, 32'h0, 32'h0, 5'd0, 32'h0, 0);
        check("err.set", 64'(err), 64'd1);
        read_chk("bad_load.x4", 5'd4);
        issue("after_err", mk(3'b000, 5'd11, OP), 32'h0, 32'h1234, 32'h0, 5'd11, 32'h1234, 1);
        check("err.sticky", 64'(err), 64'd1);

        for (int n = 0; n < 20; n++) begin
            logic [4:0]  r;
            logic [31:0] v;
            r = 5'($urandom_range(1, 31));
            v = $urandom;
            issue("rand_op", mk(3'b000, r, OP), 32'h0, v, 32'h0, r, v, 1);
        end
        for (int i = 0; i < 32; i++) read_chk("rf_scan", 5'(i));

        // Reset in the middle of a stall, between clock edges.
        issue("pre_rst", mk(3'b000, 5'd3, OP), 32'h0, 32'h33, 32'h0, 5'd3, 32'h33, 1);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk); #1;
        check("pre_rst.r_out0", 64'(r_out), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        exp_instret = 64'd0;
        rs1_addr = 5'd3;
        #1;
        check("midrst.x3_rs1", 64'(rs1_data), 64'd0);
        check("midrst.r_out", 64'(r_out), 64'd1);
        check("midrst.aw", 64'(AW_out), 64'd0);
        check("midrst.wb", 64'(WB_out), 64'd0);
        check("midrst.instret", instret, 64'd0);
        check("midrst.err", 64'(err), 64'd0);
        read_chk("midrst.x9", 5'd9);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst", mk(3'b000, 5'd12, OP), 32'h0, 32'hA5A5A5A5, 32'h0, 5'd12, 32'hA5A5A5A5, 1);
        read_chk("post_rst.x3", 5'd3);
        read_chk("post_rst.x12", 5'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
